difftest_int_reg_shadow: RTL and testbench

- Architectural integer register shadow that sits directly upstream of the difftest integer-register-state DPI block.
- Consumes per-cycle commit writebacks from the core's retire stage and maintains a committed-only copy of x0..x31.
- Drives a frozen-on-demand snapshot onto io_value_0..io_value_31, so the DPI reader always sees a consistent instruction-boundary state.
- Also provides a retired-instruction count and a step strobe that tell the C side when to compare.

---
 rtl/difftest_pkg.sv | 17 +
 rtl/difftest_commit_merge.sv | 45 ++++
 rtl/difftest_int_reg_shadow.sv | 149 ++++++++++++++
 tb/tb_difftest_int_reg_shadow.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/difftest_pkg.sv
`default_nettype none
// ============================================================================
// Module      : difftest_pkg
// Description : Shared sizing constants and types for the difftest
//               integer-register shadow.
// Revision    : 1.0 - initial release
// ============================================================================
package difftest_pkg;

    localparam int unsigned XLEN        = 64;
    localparam int unsigned NR_INT_REGS = 32;
    localparam int unsigned COMMIT_W    = 2;

    typedef logic [4:0] reg_idx_t;

endpackage : difftest_pkg
`default_nettype wire

// File: rtl/difftest_commit_merge.sv
`default_nettype none
// ============================================================================
// Module      : difftest_commit_merge
// Description : Folds one cycle of commit writebacks into the live register
//               file and counts retired instructions (purely combinational).
// Revision    : 1.0 - initial release
// ============================================================================
module difftest_commit_merge
    import difftest_pkg::NR_INT_REGS, difftest_pkg::reg_idx_t;
#(
    parameter int unsigned XLEN     = difftest_pkg::XLEN,
    parameter int unsigned COMMIT_W = difftest_pkg::COMMIT_W
) (
    input  logic [NR_INT_REGS-1:1][XLEN-1:0] live,
    input  logic [COMMIT_W-1:0]              commit_valid,
    input  logic [COMMIT_W-1:0]              commit_wen,
    input  logic [5*COMMIT_W-1:0]            commit_waddr,
    input  logic [XLEN*COMMIT_W-1:0]         commit_wdata,
    output logic [NR_INT_REGS-1:1][XLEN-1:0] next_live,
    output logic [XLEN-1:0]                  commit_cnt
);

    // x0 has no storage row, so an address of 0 can never match below.
    // Ports are scanned oldest to youngest so the youngest write wins.
    always_comb begin
        next_live = live;
        for (int r = 1; r < NR_INT_REGS; r++) begin
            for (int p = 0; p < COMMIT_W; p++) begin
                if (commit_valid[p] && commit_wen[p] &&
                    (commit_waddr[5*p +: 5] == reg_idx_t'(r))) begin
                    next_live[r] = commit_wdata[XLEN*p +: XLEN];
                end
            end
        end
    end

    always_comb begin
        commit_cnt = '0;
        for (int p = 0; p < COMMIT_W; p++) begin
            commit_cnt = commit_cnt + XLEN'(commit_valid[p]);
        end
    end

endmodule : difftest_commit_merge
`default_nettype wire

// File: rtl/difftest_int_reg_shadow.sv
`default_nettype none
// ============================================================================
// Module      : difftest_int_reg_shadow
// Description : Committed-only x0..x31 shadow with a freezable snapshot,
//               retired-instruction count and compare step strobe.
// Revision    : 1.0 - initial release
// ============================================================================
module difftest_int_reg_shadow
    import difftest_pkg::NR_INT_REGS;
#(
    parameter int unsigned XLEN     = difftest_pkg::XLEN,
    parameter int unsigned COMMIT_W = difftest_pkg::COMMIT_W
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic [COMMIT_W-1:0]      commit_valid,
    input  logic [COMMIT_W-1:0]      commit_wen,
    input  logic [5*COMMIT_W-1:0]    commit_waddr,
    input  logic [XLEN*COMMIT_W-1:0] commit_wdata,
    input  logic                     freeze,
    output logic [XLEN-1:0]          io_value_0,
    output logic [XLEN-1:0]          io_value_1,
    output logic [XLEN-1:0]          io_value_2,
    output logic [XLEN-1:0]          io_value_3,
    output logic [XLEN-1:0]          io_value_4,
    output logic [XLEN-1:0]          io_value_5,
    output logic [XLEN-1:0]          io_value_6,
    output logic [XLEN-1:0]          io_value_7,
    output logic [XLEN-1:0]          io_value_8,
    output logic [XLEN-1:0]          io_value_9,
    output logic [XLEN-1:0]          io_value_10,
    output logic [XLEN-1:0]          io_value_11,
    output logic [XLEN-1:0]          io_value_12,
    output logic [XLEN-1:0]          io_value_13,
    output logic [XLEN-1:0]          io_value_14,
    output logic [XLEN-1:0]          io_value_15,
    output logic [XLEN-1:0]          io_value_16,
    output logic [XLEN-1:0]          io_value_17,
    output logic [XLEN-1:0]          io_value_18,
    output logic [XLEN-1:0]          io_value_19,
    output logic [XLEN-1:0]          io_value_20,
    output logic [XLEN-1:0]          io_value_21,
    output logic [XLEN-1:0]          io_value_22,
    output logic [XLEN-1:0]          io_value_23,
    output logic [XLEN-1:0]          io_value_24,
    output logic [XLEN-1:0]          io_value_25,
    output logic [XLEN-1:0]          io_value_26,
    output logic [XLEN-1:0]          io_value_27,
    output logic [XLEN-1:0]          io_value_28,
    output logic [XLEN-1:0]          io_value_29,
    output logic [XLEN-1:0]          io_value_30,
    output logic [XLEN-1:0]          io_value_31,
    output logic [XLEN-1:0]          io_instr_cnt,
    output logic                     step_valid
);

    logic [NR_INT_REGS-1:1][XLEN-1:0] r_live;
    logic [NR_INT_REGS-1:1][XLEN-1:0] r_snap;
    logic [NR_INT_REGS-1:1][XLEN-1:0] w_next_live;
    logic [XLEN-1:0]                  r_live_cnt;
    logic [XLEN-1:0]                  r_instr_cnt;
    logic [XLEN-1:0]                  w_commit_cnt;
    logic [XLEN-1:0]                  w_next_cnt;
    logic                             r_pending;
    logic                             r_step_valid;
    logic                             w_any_commit;

    difftest_commit_merge #(
        .XLEN     (XLEN),
        .COMMIT_W (COMMIT_W)
    ) u_merge (
        .live         (r_live),
        .commit_valid (commit_valid),
        .commit_wen   (commit_wen),
        .commit_waddr (commit_waddr),
        .commit_wdata (commit_wdata),
        .next_live    (w_next_live),
        .commit_cnt   (w_commit_cnt)
    );

    assign w_any_commit = |commit_valid;
    assign w_next_cnt   = r_live_cnt + w_commit_cnt;

    // The live side always absorbs commits; only the snapshot side freezes.
    // Commits seen while frozen are remembered in r_pending so the release
    // edge still produces exactly one step strobe.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_live       <= '0;
            r_snap       <= '0;
            r_live_cnt   <= '0;
            r_instr_cnt  <= '0;
            r_pending    <= 1'b0;
            r_step_valid <= 1'b0;
        end else begin
            r_live     <= w_next_live;
            r_live_cnt <= w_next_cnt;
            if (!freeze) begin
                r_snap       <= w_next_live;
                r_instr_cnt  <= w_next_cnt;
                r_step_valid <= w_any_commit | r_pending;
                r_pending    <= 1'b0;
            end else begin
                r_step_valid <= 1'b0;
                if (w_any_commit) begin
                    r_pending <= 1'b1;
                end
            end
        end
    end

    assign io_instr_cnt = r_instr_cnt;
    assign step_valid   = r_step_valid;

    assign io_value_0  = '0;
    assign io_value_1  = r_snap[1];
    assign io_value_2  = r_snap[2];
    assign io_value_3  = r_snap[3];
    assign io_value_4  = r_snap[4];
    assign io_value_5  = r_snap[5];
    assign io_value_6  = r_snap[6];
    assign io_value_7  = r_snap[7];
    assign io_value_8  = r_snap[8];
    assign io_value_9  = r_snap[9];
    assign io_value_10 = r_snap[10];
    assign io_value_11 = r_snap[11];
    assign io_value_12 = r_snap[12];
    assign io_value_13 = r_snap[13];
    assign io_value_14 = r_snap[14];
    assign io_value_15 = r_snap[15];
    assign io_value_16 = r_snap[16];
    assign io_value_17 = r_snap[17];
    assign io_value_18 = r_snap[18];
    assign io_value_19 = r_snap[19];
    assign io_value_20 = r_snap[20];
    assign io_value_21 = r_snap[21];
    assign io_value_22 = r_snap[22];
    assign io_value_23 = r_snap[23];
    assign io_value_24 = r_snap[24];
    assign io_value_25 = r_snap[25];
    assign io_value_26 = r_snap[26];
    assign io_value_27 = r_snap[27];
    assign io_value_28 = r_snap[28];
    assign io_value_29 = r_snap[29];
    assign io_value_30 = r_snap[30];
    assign io_value_31 = r_snap[31];

endmodule : difftest_int_reg_shadow
`default_nettype wire

// File: tb/tb_difftest_int_reg_shadow.sv
`default_nettype none
// ============================================================================
// Module      : tb_difftest_int_reg_shadow
// Description : Directed plus random checks of the integer register shadow
//               against an architectural reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_difftest_int_reg_shadow;

    logic         clock;
    logic         reset;
    logic [1:0]   commit_valid;
    logic [1:0]   commit_wen;
    logic [9:0]   commit_waddr;
    logic [127:0] commit_wdata;
    logic         freeze;
    logic [63:0]  io_instr_cnt;
    logic         step_valid;
    logic [63:0]  dut_val [32];

    int n_assert = 0;
    int n_fail   = 0;

    // Reference model: architectural view of the retired state.
    logic [63:0] m_live [32];
    logic [63:0] m_snap [32];
    logic [63:0] m_cnt;
    logic [63:0] m_snap_cnt;
    logic        m_pend;
    logic        m_step;

    difftest_int_reg_shadow u_dut (
        .clock        (clock),
        .reset        (reset),
        .commit_valid (commit_valid),
        .commit_wen   (commit_wen),
        .commit_waddr (commit_waddr),
        .commit_wdata (commit_wdata),
        .freeze       (freeze),
        .io_value_0   (dut_val[0]),
        .io_value_1   (dut_val[1]),
        .io_value_2   (dut_val[2]),
        .io_value_3   (dut_val[3]),
        .io_value_4   (dut_val[4]),
        .io_value_5   (dut_val[5]),
        .io_value_6   (dut_val[6]),
        .io_value_7   (dut_val[7]),
        .io_value_8   (dut_val[8]),
        .io_value_9   (dut_val[9]),
        .io_value_10  (dut_val[10]),
        .io_value_11  (dut_val[11]),
        .io_value_12  (dut_val[12]),
        .io_value_13  (dut_val[13]),
        .io_value_14  (dut_val[14]),
        .io_value_15  (dut_val[15]),
        .io_value_16  (dut_val[16]),
        .io_value_17  (dut_val[17]),
        .io_value_18  (dut_val[18]),
        .io_value_19  (dut_val[19]),
        .io_value_20  (dut_val[20]),
        .io_value_21  (dut_val[21]),
        .io_value_22  (dut_val[22]),
        .io_value_23  (dut_val[23]),
        .io_value_24  (dut_val[24]),
        .io_value_25  (dut_val[25]),
        .io_value_26  (dut_val[26]),
        .io_value_27  (dut_val[27]),
        .io_value_28  (dut_val[28]),
        .io_value_29  (dut_val[29]),
        .io_value_30  (dut_val[30]),
        .io_value_31  (dut_val[31]),
        .io_instr_cnt (io_instr_cnt),
        .step_valid   (step_valid)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance the model by one clock edge using the inputs currently driven.
    task automatic model_edge();
        int n;
        if (reset) begin
            for (int i = 0; i < 32; i++) begin
                m_live[i] = '0;
                m_snap[i] = '0;
            end
            m_cnt = '0; m_snap_cnt = '0; m_pend = 1'b0; m_step = 1'b0;
        end else begin
            n = 0;
            for (int p = 0; p < 2; p++) begin
                if (commit_valid[p]) begin
                    n++;
                    if (commit_wen[p] && commit_waddr[5*p +: 5] != 5'd0)
                        m_live[commit_waddr[5*p +: 5]] = commit_wdata[64*p +: 64];
                end
            end
            m_cnt = m_cnt + 64'(n);
            if (!freeze) begin
                m_snap     = m_live;
                m_snap_cnt = m_cnt;
                m_step     = (n != 0) || m_pend;
                m_pend     = 1'b0;
            end else begin
                m_step = 1'b0;
                if (n != 0) m_pend = 1'b1;
            end
        end
    endtask

    task automatic check_all();
        for (int i = 0; i < 32; i++) chk($sformatf("x%0d", i), dut_val[i], m_snap[i]);
        chk("instr_cnt", io_instr_cnt, m_snap_cnt);
        chk("step_valid", {63'd0, step_valid}, {63'd0, m_step});
    endtask

    task automatic cyc(input logic [1:0] v, input logic [1:0] w,
                       input logic [4:0] a1, input logic [4:0] a0,
                       input logic [63:0] d1, input logic [63:0] d0,
                       input logic f, input logic r);
        commit_valid = v;
        commit_wen   = w;
        commit_waddr = {a1, a0};
        commit_wdata = {d1, d0};
        freeze       = f;
        reset        = r;
        @(posedge clock);
        model_edge();
        #1;
        check_all();
    endtask

    initial begin
        logic [4:0] ra0, ra1;
        for (int i = 0; i < 32; i++) begin
            m_live[i] = '0;
            m_snap[i] = '0;
        end
        m_cnt = '0; m_snap_cnt = '0; m_pend = 1'b0; m_step = 1'b0;

        cyc(2'b00, 2'b00, 5'd0, 5'd0, 64'd0, 64'd0, 1'b0, 1'b1);
        cyc(2'b00, 2'b00, 5'd0, 5'd0, 64'd0, 64'd0, 1'b0, 1'b1);
        chk("reset_cnt", io_instr_cnt, 64'd0);
        chk("reset_step", {63'd0, step_valid}, 64'd0);

        cyc(2'b01, 2'b01, 5'd0, 5'd5, 64'd0, 64'h1234, 1'b0, 1'b0);
        chk("x5_first", dut_val[5], 64'h1234);
        chk("cnt_first", io_instr_cnt, 64'd1);
        chk("step_first", {63'd0, step_valid}, 64'd1);
        cyc(2'b00, 2'b00, 5'd0, 5'd0, 64'd0, 64'd0, 1'b0, 1'b0);
        chk("step_one_cycle", {63'd0, step_valid}, 64'd0);

        cyc(2'b11, 2'b11, 5'd7, 5'd7, 64'hBB, 64'hAA, 1'b0, 1'b0);
        chk("x7_youngest", dut_val[7], 64'hBB);
        chk("cnt_dual", io_instr_cnt, 64'd3);

        cyc(2'b01, 2'b01, 5'd0, 5'd0, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0);
        chk("x0_zero", dut_val[0], 64'd0);
        chk("cnt_x0", io_instr_cnt, 64'd4);
        chk("step_x0", {63'd0, step_valid}, 64'd1);

        for (int k = 1; k <= 3; k++) begin
            cyc(2'b01, 2'b01, 5'd0, 5'd3, 64'd0, 64'(k), 1'b1, 1'b0);
            chk("x3_frozen", dut_val[3], 64'd0);
            chk("step_frozen", {63'd0, step_valid}, 64'd0);
            chk("cnt_frozen", io_instr_cnt, 64'd4);
        end
        cyc(2'b00, 2'b00, 5'd0, 5'd0, 64'd0, 64'd0, 1'b0, 1'b0);
        chk("x3_release", dut_val[3], 64'd3);
        chk("cnt_release", io_instr_cnt, 64'd7);
        chk("step_release", {63'd0, step_valid}, 64'd1);
        cyc(2'b00, 2'b00, 5'd0, 5'd0, 64'd0, 64'd0, 1'b0, 1'b0);
        chk("step_release_once", {63'd0, step_valid}, 64'd0);

        cyc(2'b00, 2'b01, 5'd0, 5'd4, 64'd0, 64'h77, 1'b0, 1'b0);
        chk("x4_invalid", dut_val[4], 64'd0);
        chk("cnt_invalid", io_instr_cnt, 64'd7);
        chk("step_invalid", {63'd0, step_valid}, 64'd0);

        for (int i = 0; i < 400; i++) begin
            ra0 = 5'($urandom_range(0, 31));
            ra1 = ($urandom_range(0, 3) == 0) ? ra0 : 5'($urandom_range(0, 31));
            cyc(2'($urandom), 2'($urandom), ra1, ra0,
                {$urandom, $urandom}, {$urandom, $urandom},
                ($urandom_range(0, 9) < 4), ($urandom_range(0, 99) == 0));
        end

        cyc(2'b01, 2'b01, 5'd0, 5'd9, 64'd0, 64'h11, 1'b0, 1'b0);
        cyc(2'b11, 2'b11, 5'd2, 5'd9, 64'h22, 64'h33, 1'b0, 1'b0);
        cyc(2'b01, 2'b01, 5'd0, 5'd9, 64'd0, 64'h55, 1'b0, 1'b1);
        for (int i = 0; i < 32; i++) chk("reset_clear", dut_val[i], 64'd0);
        chk("reset_cnt2", io_instr_cnt, 64'd0);
        chk("reset_step2", {63'd0, step_valid}, 64'd0);
        cyc(2'b00, 2'b00, 5'd0, 5'd0, 64'd0, 64'd0, 1'b0, 1'b0);
        chk("x9_discarded", dut_val[9], 64'd0);
        chk("cnt_after_reset", io_instr_cnt, 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule : tb_difftest_int_reg_shadow
`default_nettype wire
